// File: rtl/key_debouncer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_debouncer : 2-flop synchroniser plus per-key stability-counter debouncer
// rev 1.0
// ----------------------------------------------------------------------------
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_clean,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] busy
);

  typedef enum logic [1:0] {
    ST_STABLE_HI = 2'd0,
    ST_CHECK_LO  = 2'd1,
    ST_STABLE_LO = 2'd2,
    ST_CHECK_HI  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;

  // Released level (1) is the safe idle value for both synchroniser flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_press;
    logic             r_release;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state   <= ST_STABLE_HI;
        r_cnt     <= '0;
        r_clean   <= 1'b1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        case (r_state)
          ST_STABLE_HI: begin
            if (!r_sync2[i]) begin
              r_state <= ST_CHECK_LO;
              r_cnt   <= '0;
            end
          end
          ST_CHECK_LO: begin
            if (r_sync2[i]) begin
              r_state <= ST_STABLE_HI;
              r_cnt   <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
              r_state <= ST_STABLE_LO;
              r_cnt   <= '0;
              r_clean <= 1'b0;
              r_press <= 1'b1;
            end else begin
              r_cnt <= r_cnt + C_CNT_ONE;
            end
          end
          ST_STABLE_LO: begin
            if (r_sync2[i]) begin
              r_state <= ST_CHECK_HI;
              r_cnt   <= '0;
            end
          end
          ST_CHECK_HI: begin
            if (!r_sync2[i]) begin
              r_state <= ST_STABLE_LO;
              r_cnt   <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
              r_state   <= ST_STABLE_HI;
              r_cnt     <= '0;
              r_clean   <= 1'b1;
              r_release <= 1'b1;
            end else begin
              r_cnt <= r_cnt + C_CNT_ONE;
            end
          end
          default: begin
            r_state <= ST_STABLE_HI;
            r_cnt   <= '0;
            r_clean <= 1'b1;
          end
        endcase
      end
    end

    assign key_clean[i]     = r_clean;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_release;
    assign busy[i]          = (r_state == ST_CHECK_LO) || (r_state == ST_CHECK_HI);
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_key_debouncer : directed vector table plus multi-cycle corner sequences
// rev 1.0
// ----------------------------------------------------------------------------
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_raw = 4'b0000;
  logic [3:0] key_clean;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] busy;

  int n_vec = 0;
  int n_err = 0;

  key_debouncer #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_raw      (key_raw),
    .key_clean    (key_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] bsy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic [3:0] raw, input logic [3:0] clean,
                              input logic [3:0] press, input logic [3:0] rel, input logic [3:0] bsy);
    vec_t v;
    v.rst = rst; v.raw = raw; v.clean = clean; v.press = press; v.rel = rel; v.bsy = bsy;
    vq.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got clean/press/rel/busy=%b/%b/%b/%b want %b/%b/%b/%b", name,
               act[15:12], act[11:8], act[7:4], act[3:0], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_idx;
    int n_pulse;

    // Reset held with all keys pressed at the pins.
    for (int i = 0; i < 3; i++) add(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    // Reset released, all four keys debounce together.
    add(1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) add(1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    add(1'b1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Release all keys.
    add(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) add(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    add(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    add(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    // Clean press of key 0.
    add(1'b1, 4'b1110, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b1110, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) add(1'b1, 4'b1110, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    add(1'b1, 4'b1110, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
    add(1'b1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    // Three-cycle glitch on key 1 is rejected.
    add(1'b1, 4'b1100, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b1100, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b1100, 4'b1110, 4'b0000, 4'b0000, 4'b0010);
    add(1'b1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0010);
    add(1'b1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0010);
    add(1'b1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0000);

    foreach (vq[i]) begin
      reset   = vq[i].rst;
      key_raw = vq[i].raw;
      tick();
      chk($sformatf("vec%0d", i), {key_clean, press_pulse, release_pulse, busy},
          {vq[i].clean, vq[i].press, vq[i].rel, vq[i].bsy});
    end

    // Bounce on key 2: 0,0,1,0,0,... commits 6 edges after the last fall (index 3).
    first_idx = -1;
    n_pulse   = 0;
    for (int k = 0; k < 16; k++) begin
      key_raw = (k == 2) ? 4'b1110 : 4'b1010;
      tick();
      if (press_pulse[2]) begin
        n_pulse++;
        if (first_idx < 0) first_idx = k;
      end
    end
    chki("bounce_commit_edge", first_idx, 9);
    chki("bounce_pulse_count", n_pulse, 1);
    chk4("bounce_clean", key_clean, 4'b1010);

    // Keys 0 and 3 pressed, then released on the same edge.
    key_raw = 4'b0110;
    for (int k = 0; k < 10; k++) tick();
    chk4("simul_pressed", key_clean, 4'b0110);
    key_raw = 4'b1111;
    for (int k = 0; k < 6; k++) tick();
    chk4("simul_rel_early", release_pulse, 4'b0000);
    tick();
    chk4("simul_rel_pulse", release_pulse, 4'b1001);
    chk4("simul_clean", key_clean, 4'b1111);
    tick();
    chk4("simul_rel_clear", release_pulse, 4'b0000);

    // Reset mid-check on key 0 with cnt = 2, key held through reset.
    key_raw = 4'b1110;
    for (int k = 0; k < 5; k++) tick();
    chk4("midchk_busy", busy, 4'b0001);
    reset = 1'b0;
    tick();
    chk("midchk_reset", {key_clean, press_pulse, release_pulse, busy},
        {4'b1111, 4'b0000, 4'b0000, 4'b0000});
    reset = 1'b1;
    n_pulse = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (press_pulse[0]) n_pulse++;
    end
    chk4("midchk_pre_commit", key_clean, 4'b1111);
    chki("midchk_no_early_pulse", n_pulse, 0);
    tick();
    chk4("midchk_redebounce_press", press_pulse, 4'b0001);
    chk4("midchk_redebounce_clean", key_clean, 4'b1110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debouncer.md
# key_debouncer

Front-end conditioning stage for the board push-buttons: synchronises the raw, active-low KEY inputs into the `clk` domain, rejects contact bounce with a per-key stability counter, and presents a clean active-low level per key. Its `key_clean` outputs feed the per-key button edge FSMs directly as their `key_pressed` input. It also provides one-cycle press/release pulses for debug counters and HEX displays.

## Interface
- `N_KEYS`, default 4: number of independent keys.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a change commits (10 ms at 50 MHz). Legal minimum is 2.
- `CNT_W`, default 20: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`, input, 1: system clock, 50 MHz.
- `reset`, input, 1: reset, synchronous, active-low; clock clk.
- `key_raw`, input, N_KEYS: asynchronous board keys. 0 = pressed.
- `key_clean`, output, N_KEYS: debounced level. 0 = pressed, 1 = released.
- `press_pulse`, output, N_KEYS: 1-cycle pulse when `key_clean[i]` commits 1→0.
- `release_pulse`, output, N_KEYS: 1-cycle pulse when `key_clean[i]` commits 0→1.
- `busy`, output, N_KEYS: 1 while key i is in a CHECK state.

## Operation
- **Synchroniser.** Each key passes through a 2-flop synchroniser (s1 → s2). Both flops reset to 1.
- **Per-key FSM.** Each key has its own FSM and its own CNT_W counter. Keys are fully independent.
- **States:**
  - STABLE_HI: `key_clean` = 1. If s2 = 0, go to CHECK_LO and clear cnt.
  - CHECK_LO: if s2 = 1, go to STABLE_HI and clear cnt (glitch rejected, no output change). Otherwise, if cnt == DEBOUNCE_CYCLES-1, go to STABLE_LO. Otherwise cnt++.
  - STABLE_LO: `key_clean` = 0. If s2 = 1, go to CHECK_HI and clear cnt.
  - CHECK_HI: mirror of CHECK_LO. Commit goes to STABLE_HI; a glitch returns to STABLE_LO.
- **Outputs.** `key_clean`, `press_pulse` and `release_pulse` are registered.
  - The commit edge updates `key_clean` and raises the matching pulse for exactly one cycle.
  - `busy` = (state is CHECK_LO or CHECK_HI), decoded from the state register.
- **Counter width.** cnt never exceeds DEBOUNCE_CYCLES-1, so it does not wrap.
- **Reset values** (sampled on a clk edge with reset = 0):
  - all states STABLE_HI;
  - `key_clean` = all 1s;
  - pulses = 0, `busy` = 0, cnt = 0;
  - s1 and s2 = 1.
- **Reset mid-operation.** Reset asserted during CHECK aborts the check; no pulse is emitted. A key held pressed through reset re-debounces from STABLE_HI after reset is released.
- **Simultaneous events.** Several keys may commit on the same edge; each raises its own pulse. On a single key, press and release pulses are mutually exclusive.

## Timing
- Take edge E0 as the first edge at which the new `key_raw` level is sampled into s1.
  - E1: s2 holds the new level.
  - E2: FSM enters CHECK with cnt = 0.
  - E(2+k): cnt = k.
  - E(DEBOUNCE_CYCLES+2): commit. `key_clean` and the pulse change after this edge.
- **Latency** = DEBOUNCE_CYCLES + 2 clocks from first sample to output.
- **Glitch rejection.** A raw pulse shorter than DEBOUNCE_CYCLES clocks at s2 never changes `key_clean`.
- **Bounce.** Any bounce during CHECK restarts the full DEBOUNCE_CYCLES window once the level returns to the new value.
- **Pulse shape.** Pulses last exactly 1 cycle. Back-to-back pulses on one key are separated by at least DEBOUNCE_CYCLES+1 cycles.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 4 and N_KEYS = 4.
1. **Reset.** Hold reset = 0 for 3 edges with `key_raw` = 4'b0000 → `key_clean` = 4'b1111, pulses and `busy` = 0. Release reset → `key_clean` = 4'b1110 pattern not yet present; each key reaches 0 after exactly 6 edges.
2. **Clean press.** Drop `key_raw[0]` to 0 before E0 and hold it → `busy[0]` = 1 after E2. `key_clean[0]` = 0 and `press_pulse[0]` = 1 after E6 only. `press_pulse[0]` = 0 again after E7.
3. **Glitch.** Hold `key_raw[1]` = 0 for 3 cycles, then return to 1 → `key_clean[1]` stays 1 and no pulse occurs. `busy[1]` returns to 0.
4. **Bounce.** Drive `key_raw[2]` with 0,0,1,0,0,0,0,0… → commit occurs 6 edges after the last 1→0 transition, and exactly one `press_pulse[2]` is emitted.
5. **Simultaneous.** Release keys 0 and 3 on the same edge after both are debounced pressed → both `release_pulse` bits fire on the same cycle, and `key_clean` = 4'b1111.
6. **Reset mid-check.** Assert reset while `busy[0]` = 1 with cnt = 2 → no pulse; state is STABLE_HI and `key_clean[0]` = 1 after the reset edge.
